dot_product_reader: RTL
=======================

# dot_product_reader

Read-side sequencer for the dot-product result RAM. After the dot-product pipeline reports done, this block walks every RAM address, captures the four complex results (lanes a–d) stored at each address, and serializes them as one complex word per beat on a valid/ready output stream. It drives the RAM read addresses that the dot-product top otherwise leaves to external logic, and it sits between the result RAM and the downstream sorter/consumer.

## Interface
- WIDTH, 16, bit width of each real/imag component
- ADDR_WIDTH, 3, RAM address width
- DEPTH, 8, number of RAM addresses read per run (DEPTH ≤ 2^ADDR_WIDTH)
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-low (all state cleared on rising clk while rst=0)
- start  in  1  begin a readout run; sampled only in IDLE
- readAddrReal  out  ADDR_WIDTH  RAM read address, real banks
- readAddrImag  out  ADDR_WIDTH  RAM read address, imag banks (always equal to readAddrReal)
- ramaReal, ramaImag, rambReal, rambImag, ramcReal, ramcImag,ramdReal, ramdImag  in  WIDTH each  RAM read data, registered RAM output (valid one clk after the address)
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts beat when out_valid & out_ready at a rising edge
- outReal, outImag  out  WIDTH  current complex word
- outLane  out  2  lane of current word (0=a, 1=b, 2=c, 3=d)
- outIndex  out  ADDR_WIDTH  RAM address of current word
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the final beat has been accepted

## Operation
- State machine: IDLE, FETCH, LOAD, SEND, DONE.
- IDLE: idx=0, lane=0. start=1 → FETCH.
- FETCH: readAddr = idx held stable; the RAM registers data at the end of this cycle. Next state is LOAD.
- LOAD: RAM data valid. All 8 words are latched into holding registers at the end of the cycle; lane=0. Next state is SEND.
- SEND: out_valid=1, outReal/outImag = held lane `lane`, outLane=lane, outIndex=idx. On handshake:
  - lane<3: lane+1, stay in SEND.
  - lane=3 and idx<DEPTH-1: idx+1, lane=0, go to FETCH.
  - lane=3 and idx=DEPTH-1: go to DONE.
- Without a handshake, all outputs hold unchanged; out_valid never drops before acceptance.
- DONE: done=1 for exactly one cycle, then IDLE with idx=0.
- readAddrReal = readAddrImag = idx register in all states. In IDLE, idx is 0.
- Data is passed through bit-exact, with no arithmetic. Holding registers change only in LOAD, so RAM writes after LOAD cannot corrupt beats in flight.
- start while busy is ignored and is not queued. start held high in DONE has no effect; the start sampled in the following IDLE cycle launches a new run.
- Reset (rst=0 at any edge, including mid-run) → IDLE. out_valid=0, done=0, busy=0, idx=0, lane=0, outReal=outImag=0, outLane=0, outIndex=0, and holding registers 0. The next run restarts from address 0.

## Timing
- start sampled high at edge N → FETCH after N, LOAD after N+1, first out_valid=1 after edge N+2.
- Per address: 2 overhead cycles (FETCH, LOAD) plus 4 SEND beats, so at least 6 cycles.
- With out_ready tied high, the last beat is accepted at edge N+6·DEPTH (N+48 at defaults). done=1 during the following cycle; busy=0 and IDLE after edge N+6·DEPTH+1.
- Each cycle out_ready is low in SEND adds exactly one cycle. out_valid stays low in FETCH, LOAD, DONE, and IDLE.
- done and out_valid are never high in the same cycle.

## Test plan
- Basic run: the RAM model holds aReal=16'h0A00+k, aImag=16'h1A00+k, bReal=16'h0B00+k, …, dImag=16'h1D00+k at address k; out_ready=1; pulse start. Required:
  - 32 beats in order k=0..7, lane a..d, with matching values and outIndex/outLane.
  - First valid 2 cycles after the start edge; done exactly 1 cycle after the 32nd beat.
  - readAddrReal = readAddrImag throughout.
- Backpressure: out_ready random at 30% high. Required:
  - Same 32-beat sequence.
  - outReal/outImag/outLane/outIndex stable while out_valid & !out_ready.
  - No beat dropped or duplicated.
- Stale-data isolation: the RAM model changes address-3 contents during SEND of index 3. Required: beats for index 3 show the contents latched in LOAD.
- start while busy: pulse start at beats 5 and 20. Required: sequence unaffected, one done only, no restart.
- Reset mid-run: rst=0 for one edge at beat 10, then start again. Required:
  - Immediately after the reset edge: out_valid=0, busy=0, done=0, readAddr=0.
  - The new run begins at index 0, lane a, and completes all 32 beats.
- Back-to-back runs: start held high continuously. Required:
  - Second run's first out_valid appears 2 cycles after the IDLE cycle that follows done.
  - Both runs produce all 32 beats.

Source files
------------

// File: rtl/dot_product_reader.sv
`default_nettype none
// ============================================================================
//  Module   : dot_product_reader
//  Purpose  : Walks the dot-product result RAM after a run completes, latches
//             the four complex lane results at each address and serializes
//             them one complex word per beat on a valid/ready stream.
//  Revision : 1.0 - initial release
// ============================================================================
module dot_product_reader #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] readAddrReal,
    output logic [ADDR_WIDTH-1:0] readAddrImag,
    input  logic [WIDTH-1:0]      ramaReal,
    input  logic [WIDTH-1:0]      ramaImag,
    input  logic [WIDTH-1:0]      rambReal,
    input  logic [WIDTH-1:0]      rambImag,
    input  logic [WIDTH-1:0]      ramcReal,
    input  logic [WIDTH-1:0]      ramcImag,
    input  logic [WIDTH-1:0]      ramdReal,
    input  logic [WIDTH-1:0]      ramdImag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      outReal,
    output logic [WIDTH-1:0]      outImag,
    output logic [1:0]            outLane,
    output logic [ADDR_WIDTH-1:0] outIndex,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_SEND  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] idx;
    logic [1:0]            lane;
    logic [WIDTH-1:0]      hold_real [4];
    logic [WIDTH-1:0]      hold_imag [4];

    // Sequencer: address walk, lane stepping, holding-register capture and
    // registered handshake/status flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            lane      <= 2'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                hold_real[i] <= '0;
                hold_imag[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    idx  <= '0;
                    lane <= 2'd0;
                    if (start) begin
                        state <= S_FETCH;
                        busy  <= 1'b1;
                    end
                end
                // Address is already stable; RAM registers its output at this edge.
                S_FETCH: begin
                    state <= S_LOAD;
                end
                // Capture all lanes at once so later RAM writes cannot disturb the beats.
                S_LOAD: begin
                    hold_real[0] <= ramaReal;
                    hold_imag[0] <= ramaImag;
                    hold_real[1] <= rambReal;
                    hold_imag[1] <= rambImag;
                    hold_real[2] <= ramcReal;
                    hold_imag[2] <= ramcImag;
                    hold_real[3] <= ramdReal;
                    hold_imag[3] <= ramdImag;
                    lane         <= 2'd0;
                    out_valid    <= 1'b1;
                    state        <= S_SEND;
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (lane != 2'd3) begin
                            lane <= lane + 2'd1;
                        end else begin
                            out_valid <= 1'b0;
                            if (idx != LAST_IDX) begin
                                idx   <= idx + ADDR_WIDTH'(1);
                                lane  <= 2'd0;
                                state <= S_FETCH;
                            end else begin
                                done  <= 1'b1;
                                state <= S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    idx   <= '0;
                    lane  <= 2'd0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state     <= S_IDLE;
                    idx       <= '0;
                    lane      <= 2'd0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign readAddrReal = idx;
    assign readAddrImag = idx;
    assign outReal      = hold_real[lane];
    assign outImag      = hold_imag[lane];
    assign outLane      = lane;
    assign outIndex     = idx;

endmodule
`default_nettype wire
